// File: rtl/serial_adder_pkg.sv
// Shared types for the serial word adder: controller FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } adder_state_e;

endpackage

// File: rtl/serial_word_adder_ctrl_if.sv
// Word-level operand/result handshake bundle for the serial word adder.
interface serial_word_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  // Producer/consumer side of the adder.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out
  );

endinterface

// File: rtl/serial_adder_bit_slice.sv
// One-bit full-adder cell with its own carry register; one bit per enabled clock.
module serial_adder_bit_slice (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_d
);

  logic carry_r;
  logic half_s;

  assign half_s  = a ^ b;
  assign sum     = half_s ^ carry_r;
  assign carry_d = (a & b) | (carry_r & half_s);

  // Carry register: clear wins over enable so a new word always starts from zero carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r <= 1'b0;
    end else if (clr) begin
      carry_r <= 1'b0;
    end else if (en) begin
      carry_r <= carry_d;
    end else begin
      carry_r <= carry_r;
    end
  end

endmodule

// File: rtl/serial_word_adder_ctrl.sv
// Word sequencer: accepts an operand pair, adds it LSB-first through one bit
// slice over WIDTH clocks, then holds the sum and carry until the consumer accepts it.
module serial_word_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_word_adder_ctrl_if.slave   bus,
  output logic                      busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  adder_state_e     state_r, state_n_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, sum_sh_r, sum_sh_n_s;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_out_r;
  logic             in_ready_r, out_valid_r, busy_r;
  logic             accept_s, step_s, last_s;
  logic             slice_sum_s, slice_carry_d_s;

  serial_adder_bit_slice u_slice (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept_s),
    .en      (step_s),
    .a       (a_sh_r[0]),
    .b       (b_sh_r[0]),
    .sum     (slice_sum_s),
    .carry_d (slice_carry_d_s)
  );

  // Next-state and per-cycle control decode; the new sum bit enters at the MSB.
  always_comb begin
    state_n_s  = state_r;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    last_s     = 1'b0;
    sum_sh_n_s = sum_sh_r >> 1;
    sum_sh_n_s[WIDTH-1] = slice_sum_s;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s  = 1'b1;
          state_n_s = RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          last_s    = 1'b1;
          state_n_s = DONE;
        end else begin
          state_n_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      in_ready_r  <= (state_n_s == IDLE);
      out_valid_r <= (state_n_s == DONE);
      busy_r      <= (state_n_s != IDLE);
    end
  end

  // Operand/sum shift registers, bit counter and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      sum_sh_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
    end else if (accept_s) begin
      a_sh_r   <= bus.a;
      b_sh_r   <= bus.b;
      sum_sh_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (step_s) begin
      a_sh_r   <= a_sh_r >> 1;
      b_sh_r   <= b_sh_r >> 1;
      sum_sh_r <= sum_sh_n_s;
      cnt_r    <= cnt_r + CNT_ONE;
      if (last_s) begin
        sum_r       <= sum_sh_n_s;
        carry_out_r <= slice_carry_d_s;
      end else begin
        sum_r       <= sum_r;
        carry_out_r <= carry_out_r;
      end
    end else begin
      a_sh_r <= a_sh_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign busy          = busy_r;

endmodule
